// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD-to-binary converter.
// Digit width, FSM states and the minimum binary width check.
package bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Smallest w with 2**w >= 10**digits
  function automatic int min_bin_w(input int digits);
    longint unsigned p;
    int w;
    p = 64'd1;
    for (int i = 0; i < digits; i++) p = p * 64'd10;
    w = 0;
    while ((64'd1 << w) < p) w++;
    return w;
  endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// One-digit reverse double-dabble correction.
// Digits that reach 8 after a right shift lose 3.
module bcd_digit_corr
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);

  assign q = (d >= 4'd8) ? d - 4'd3 : d;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter, one shift per clock.
// Define BCD2BIN_DIGIT_CHECK_EN to flag and zero invalid digits.
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DIGIT_W*DIGITS-1:0] in_bcd,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [BIN_W-1:0]        out_bin,
  output logic                    out_valid,
  output logic                    out_err
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);

  if (BIN_W < min_bin_w(DIGITS)) begin : g_bad_w
    $error("bcd2bin_seq: BIN_W too small for DIGITS");
  end

  state_t           state;
  state_t           state_nx;
  logic [BCD_W-1:0] bcd_reg;
  logic [BCD_W-1:0] bcd_sh;
  logic [BCD_W-1:0] bcd_cor;
  logic [BIN_W-1:0] bin_reg;
  logic [BIN_W-1:0] bin_sh;
  logic [CNT_W-1:0] cnt;
  logic             fire;
  logic             last;
  logic             err_q;

  assign fire   = in_valid && in_ready;
  assign last   = (cnt == CNT_W'(BIN_W - 1));
  assign bcd_sh = bcd_reg >> 1;
  assign bin_sh = {bcd_reg[0], bin_reg[BIN_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_digit_corr u_corr (
      .d (bcd_sh[g*DIGIT_W +: DIGIT_W]),
      .q (bcd_cor[g*DIGIT_W +: DIGIT_W])
    );
  end

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic err_in;

  always_comb begin
    err_in = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (in_bcd[i*DIGIT_W +: DIGIT_W] > 4'd9)
        err_in = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (fire)
      err_q <= err_in;
  end
`else
  assign err_q = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = SHIFT;
      end
      SHIFT: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Result lands on the last shift edge so it is stable during DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      out_bin <= '0;
      out_err <= 1'b0;
    end else if (fire) begin
      bcd_reg <= in_bcd;
      bin_reg <= '0;
      cnt     <= '0;
    end else if (state == SHIFT) begin
      bcd_reg <= bcd_cor;
      bin_reg <= bin_sh;
      cnt     <= cnt + 1'b1;
      if (last) begin
        out_bin <= err_q ? '0 : bin_sh;
        out_err <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Scoreboard bench for bcd2bin_seq.
// Define BCD2BIN_DIGIT_CHECK_EN to cover the digit checker.
module tb_bcd2bin_seq;

  logic        clk;
  logic        rst;
  logic [15:0] in_bcd;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] out_bin;
  logic        out_valid;
  logic        out_err;

  int n_tests;
  int n_fail;
  int cyc;

  logic [14:0] exp_q[$];
  int          acc_q[$];

  bcd2bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bcd    (in_bcd),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bin   (out_bin),
    .out_valid (out_valid),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] bin2bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        logic [14:0] e;
        int a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("out_bin", {18'd0, out_bin}, {18'd0, e[13:0]});
        chk("out_err", {31'd0, out_err}, {31'd0, e[14]});
        chk("latency", cyc - a, 14);
      end
    end
  end

  // Caller sits on a negedge; returns on the negedge where in_ready rises
  task automatic send(input logic [15:0] bcd, input logic [13:0] eb,
                      input logic ee);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    in_bcd   = bcd;
    in_valid = 1'b1;
    exp_q.push_back({ee, eb});
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_bcd   = 16'($urandom);
    n = 0;
    while (!in_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", n, 15);
    chk("hold_bin", {18'd0, out_bin}, {18'd0, eb});
    chk("hold_err", {31'd0, out_err}, {31'd0, ee});
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] vals[2];
    int n;
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_bcd   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, in_ready}, 1);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_bin", {18'd0, out_bin}, 0);
    chk("rst_err", {31'd0, out_err}, 0);
    rst = 1'b0;
    @(negedge clk);

    send(16'h9999, 14'd9999, 1'b0);
    send(16'h0000, 14'd0, 1'b0);
    send(16'h4095, 14'h0FFF, 1'b0);

    // Reset and request in the same cycle: reset wins
    rst      = 1'b1;
    in_valid = 1'b1;
    in_bcd   = 16'h5555;
    @(negedge clk);
    chk("rst_vs_valid", {31'd0, in_ready}, 1);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);

    // Abort a 0x1234 conversion with cnt at 7
    in_bcd   = 16'h1234;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_bin", {18'd0, out_bin}, 0);
    chk("abort_ready", {31'd0, in_ready}, 1);
    chk("abort_valid", {31'd0, out_valid}, 0);
    chk("abort_err", {31'd0, out_err}, 0);
    repeat (20) @(negedge clk);
    send(16'h0042, 14'd42, 1'b0);

`ifdef BCD2BIN_DIGIT_CHECK_EN
    send(16'h1A23, 14'd0, 1'b1);
    repeat (3) @(negedge clk);
    chk("err_hold_idle", {31'd0, out_err}, 1);
`endif
    send(16'h0123, 14'd123, 1'b0);

    // in_valid held high while in_bcd churns during the conversion
    vals[0] = 16'h0321;
    vals[1] = 16'h8765;
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!in_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("hold_ready", {31'd0, in_ready}, 1);
      in_bcd = vals[k];
      exp_q.push_back({1'b0, (k == 0) ? 14'd321 : 14'd8765});
      acc_q.push_back(cyc + 1);
      repeat (15) begin
        @(negedge clk);
        in_bcd = bin2bcd($urandom_range(0, 9999));
      end
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 4096; v++)
      send(bin2bcd(v), 14'(v), 1'b0);

    repeat (20) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
- Sequential BCD-to-binary converter; the inverse of the team's combinational binary-to-BCD block.
- Uses reverse double-dabble: one right shift plus one digit correction per clock.
- Sits between keypad/seven-segment digit entry logic and the binary datapath.
- Valid/ready input and a one-cycle result strobe on the output.

Parameters:
- DIGITS, 4, number of packed BCD digits at the input.
- BIN_W, 14, binary result width; must be >= ceil(log2(10^DIGITS)) (14 for 4 digits).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_bcd  in  4*DIGITS  packed BCD, most significant digit in the top nibble.
- in_valid  in  1  input request.
- in_ready  out  1  high only in IDLE; transfer happens when in_valid && in_ready.
- out_bin  out  BIN_W  result; holds its value until the next DONE.
- out_valid  out  1  one-cycle strobe when out_bin updates.
- out_err  out  1  invalid-digit flag; see Optional Feature.

Behaviour:
- Reset values (applied at the first clk edge with rst=1): state=IDLE, out_bin=0, out_valid=0, out_err=0, in_ready=1, internal shift register and counter all 0.
- Internal shift register: {bcd_reg[4*DIGITS-1:0], bin_reg[BIN_W-1:0]}.
- Counter: cnt, width clog2(BIN_W).
- IDLE:
  - in_ready=1.
  - On transfer: bcd_reg<=in_bcd, bin_reg<=0, cnt<=0, capture digit-error flag, go to SHIFT.
- SHIFT (in_ready=0):
  - Each cycle: shift the full register right by 1 (bcd_reg LSB enters bin_reg MSB).
  - Then, for every digit of the shifted bcd_reg whose value is >= 8, subtract 3 (4-bit, no borrow across digits).
  - Store the result and increment cnt.
  - When cnt==BIN_W-1 on this cycle, go to DONE.
- DONE (in_ready=0):
  - out_bin<=bin_reg, out_valid=1 for exactly this cycle, out_err<=captured flag.
  - Go to IDLE.
- Latency and throughput:
  - Transfer at edge E0; out_valid is high in the cycle after edge E_BIN_W (14 cycles by default).
  - in_ready returns high after E_BIN_W+1.
  - Minimum accept-to-accept period is BIN_W+2 cycles.
- in_valid while busy is ignored; the input is not latched and there is no queueing.
- in_bcd may change freely after the transfer edge.
- rst during SHIFT/DONE aborts the conversion: all outputs return to reset values; no out_valid is produced for the aborted operation.
- rst and in_valid in the same cycle: reset wins, no transfer.
- Result is exact for all valid inputs 0 .. 10^DIGITS-1. Upper bits of out_bin are 0 when BIN_W exceeds the minimum width.

Optional Feature:
- Macro: BCD2BIN_DIGIT_CHECK_EN.
- Enabled:
  - At transfer, any in_bcd digit > 9 sets the captured error flag.
  - At DONE: out_err=1 and out_bin<=0 (forced to 0, not the algorithm output).
  - out_err holds until the next DONE or reset.
- Disabled:
  - No checker logic; out_err is tied to 0.
  - Invalid digits produce the raw algorithm output, which is unspecified but deterministic.

Decomposition:
- Package bcd_pkg:
  - DIGIT_W=4.
  - State enum {IDLE, SHIFT, DONE}.
  - Function min_bin_w(digits) for parameter checking (elaboration-time assertion BIN_W >= min_bin_w(DIGITS)).
- One sub-module, bcd_digit_corr: combinational, 4-bit in/out, out = in>=8 ? in-3 : in. Instantiated DIGITS times with generate.

Test Plan:
- in_bcd=0x9999 -> out_bin=9999 (0x270F), out_valid one cycle, exactly 14 cycles after the accept edge, out_err=0.
- in_bcd=0x0000 -> out_bin=0. Then in_bcd=0x4095 -> out_bin=0x0FFF. in_ready low for 15 cycles after each accept.
- Round-trip: every value 0..4095 through the team's binary-to-BCD block, then into this block -> out_bin equals the original value; back-to-back at the max rate of one per 16 cycles.
- in_valid held high continuously with in_bcd changing during SHIFT -> only the values present at in_ready=1 edges are converted; no extra out_valid.
- Assert rst for one cycle at cnt=7 of a 0x1234 conversion -> outputs zero, no out_valid; next conversion 0x0042 -> 42.
- With BCD2BIN_DIGIT_CHECK_EN: 0x1A23 -> out_err=1, out_bin=0. Next 0x0123 -> out_err=0, out_bin=123. Without the macro, out_err stays 0.
